// File: rtl/lcd_bus_driver_if.sv
// Command handshake from the LCD sequencer plus the panel-side bus and status.
interface lcd_bus_driver_if;
  logic [9:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_db;
  logic       lcd_e;
  logic       lcd_on;
  logic       busy;
  logic       rw_drop;

  modport master (
    output cmd_data, cmd_valid,
    input  cmd_ready, lcd_rs, lcd_rw, lcd_db, lcd_e, lcd_on, busy, rw_drop
  );

  modport slave (
    input  cmd_data, cmd_valid,
    output cmd_ready, lcd_rs, lcd_rw, lcd_db, lcd_e, lcd_on, busy, rw_drop
  );
endinterface

// File: rtl/lcd_bus_driver.sv
// HD44780 bus-cycle generator: buffers {RS,RW,DB} words in a small FIFO and
// plays each one out as setup / E pulse / hold / execution wait, all counted
// in clock cycles.
module lcd_bus_driver #(
  parameter int FIFO_DEPTH  = 4,
  parameter int T_AS        = 2,
  parameter int T_PW        = 12,
  parameter int T_H         = 1,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CNT_W       = 17
) (
  input  logic            clk,
  input  logic            rst,
  lcd_bus_driver_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

  // FIFO storage and bookkeeping
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          full, empty, push, pop;
  logic [9:0]    head;

  // Sequencer state
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, exec_last;
  logic             lcd_e_q, e_n;
  logic             rs_q, rs_n;
  logic [7:0]       db_q, db_n;
  logic             long_q, long_n;
  logic             drop_q, drop_n;
  logic             on_q;
  logic             dispatch;

  assign full      = (level == (AW+1)'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign head      = mem[rd_ptr];
  assign push      = bus.cmd_valid && bus.cmd_ready;
  assign exec_last = long_q ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);

  // on_q is 0 only while in reset, so ready is held low until the first
  // cycle after release.
  assign bus.cmd_ready = on_q && !full;
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_db    = db_q;
  assign bus.lcd_e     = lcd_e_q;
  assign bus.lcd_on    = on_q;
  assign bus.busy      = !empty || (state != IDLE);
  assign bus.rw_drop   = drop_q;

  // FIFO data write; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.cmd_data;
  end

  // FIFO pointers and fill level; simultaneous push and pop leave level as is
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // State, timing counter and registered bus outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lcd_e_q <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= '0;
      long_q  <= 1'b0;
      drop_q  <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      lcd_e_q <= e_n;
      rs_q    <= rs_n;
      db_q    <= db_n;
      long_q  <= long_n;
      drop_q  <= drop_n;
      on_q    <= 1'b1;
    end
  end

  // Next-state, counter and bus-output decode
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CNT_W'(1);
    e_n      = lcd_e_q;
    rs_n     = rs_q;
    db_n     = db_q;
    long_n   = long_q;
    drop_n   = 1'b0;
    pop      = 1'b0;
    dispatch = 1'b0;
    case (state)
      IDLE: dispatch = 1'b1;
      SETUP:
        if (cnt == CNT_W'(T_AS - 1)) begin
          state_n = PULSE;
          cnt_n   = '0;
          e_n     = 1'b1;
        end
      PULSE:
        if (cnt == CNT_W'(T_PW - 1)) begin
          state_n = HOLD;
          cnt_n   = '0;
          e_n     = 1'b0;
        end
      HOLD:
        if (cnt == CNT_W'(T_H - 1)) begin
          state_n = EXEC;
          cnt_n   = '0;
        end
      // The last EXEC cycle also performs the IDLE dispatch, so a queued
      // word loads exactly T_AS+T_PW+T_H+T_EXEC cycles after the previous one.
      EXEC:
        if (cnt == exec_last) begin
          state_n  = IDLE;
          dispatch = 1'b1;
        end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        e_n     = 1'b0;
      end
    endcase

    if (dispatch) begin
      cnt_n = '0;
      if (!empty) begin
        pop = 1'b1;
        if (head[8]) begin
          drop_n = 1'b1;
        end else begin
          state_n = SETUP;
          rs_n    = head[9];
          db_n    = head[7:0];
          long_n  = !head[9] && (head[7:1] == 7'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Bench for lcd_bus_driver: table of words with expected bus values, scoreboard
// checked on every E rising edge, timing measured against a free cycle count.
module tb_lcd_bus_driver;

  localparam int T_AS  = 2;
  localparam int T_PW  = 12;
  localparam int T_H   = 1;
  localparam int T_EX  = 2000;
  localparam int T_EXL = 8200;
  localparam int GAP   = T_AS + T_PW + T_H + T_EX;

  typedef struct {
    logic [9:0] cmd;
    logic       rs;
    logic [7:0] db;
    logic       drop;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  lcd_bus_driver_if bus();

  lcd_bus_driver #(
    .FIFO_DEPTH (4),
    .T_AS       (T_AS),
    .T_PW       (T_PW),
    .T_H        (T_H),
    .T_EXEC     (T_EX),
    .T_EXEC_LONG(T_EXL),
    .CNT_W      (17)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_fail   = 0;
  vec_t       tbl [21];
  logic [8:0] exp_q [$];
  int         rise_q [$];
  int         rises = 0;
  int         drops = 0;
  int         last_push = 0;
  logic       e_prev = 1'b0;
  int         hi_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and E-pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      e_prev = 1'b0;
      hi_cnt = 0;
    end else begin
      if (bus.rw_drop) drops++;
      if (bus.lcd_e && !e_prev) begin
        rises++;
        rise_q.push_back(cyc);
        check("rw_low_on_e", int'(bus.lcd_rw), 0);
        check("sb_word_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("bus_word", int'({bus.lcd_rs, bus.lcd_db}), int'(exp_q.pop_front()));
      end
      if (bus.lcd_e) hi_cnt++;
      else if (e_prev) begin
        check("e_width", hi_cnt, T_PW);
        hi_cnt = 0;
      end
      e_prev = bus.lcd_e;
    end
  end

  // Called on a falling edge; returns on the falling edge after acceptance
  task automatic push(input int idx);
    int t = 0;
    bus.cmd_data  = tbl[idx].cmd;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) check("push_ready", int'(bus.cmd_ready), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    last_push = cyc;
    if (!tbl[idx].drop) exp_q.push_back({tbl[idx].rs, tbl[idx].db});
  endtask

  task automatic wait_idle(output int at);
    int t = 0;
    while (bus.busy && t < 30000) begin
      @(negedge clk);
      t++;
    end
    check("idle_reached", int'(bus.busy), 0);
    check("sb_drained", exp_q.size(), 0);
    at = cyc;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, n0, d0, la;
    tbl = '{
      '{10'h001, 1'b0, 8'h01, 1'b0},   // 0  clear (long)
      '{10'h250, 1'b1, 8'h50, 1'b0},   // 1
      '{10'h038, 1'b0, 8'h38, 1'b0},   // 2
      '{10'h030, 1'b0, 8'h30, 1'b0},   // 3..8 back-to-back burst
      '{10'h00E, 1'b0, 8'h0E, 1'b0},
      '{10'h006, 1'b0, 8'h06, 1'b0},
      '{10'h250, 1'b1, 8'h50, 1'b0},
      '{10'h252, 1'b1, 8'h52, 1'b0},
      '{10'h241, 1'b1, 8'h41, 1'b0},
      '{10'h24F, 1'b1, 8'h4F, 1'b0},   // 9..11 read word dropped in between
      '{10'h1FF, 1'b0, 8'h00, 1'b1},
      '{10'h248, 1'b1, 8'h48, 1'b0},
      '{10'h261, 1'b1, 8'h61, 1'b0},   // 12..17 push/pop at level 3
      '{10'h262, 1'b1, 8'h62, 1'b0},
      '{10'h263, 1'b1, 8'h63, 1'b0},
      '{10'h264, 1'b1, 8'h64, 1'b0},
      '{10'h265, 1'b1, 8'h65, 1'b0},
      '{10'h266, 1'b1, 8'h66, 1'b0},
      '{10'h231, 1'b1, 8'h31, 1'b0},   // 18..20 reset mid-pulse
      '{10'h232, 1'b1, 8'h32, 1'b0},
      '{10'h233, 1'b1, 8'h33, 1'b0}
    };
    bus.cmd_data  = '0;
    bus.cmd_valid = 1'b0;

    // 1. reset held 3 cycles, then a clear command
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", int'(bus.cmd_ready), 0);
      check("rst_on", int'(bus.lcd_on), 0);
      check("rst_e", int'(bus.lcd_e), 0);
      check("rst_busy", int'(bus.busy), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("on_after_rst", int'(bus.lcd_on), 1);
    check("ready_after_rst", int'(bus.cmd_ready), 1);
    check("db_after_rst", int'(bus.lcd_db), 0);
    rise_q.delete();
    push(0);
    wait_idle(at);
    check("t1_rises", rise_q.size(), 1);
    if (rise_q.size() > 0) check("t1_e_latency", rise_q[0], last_push + 1 + T_AS);
    check("t1_busy_drop", at, last_push + 1 + T_AS + T_PW + T_H + T_EXL);
    check("t1_db_held", int'(bus.lcd_db), 8'h01);

    // 2. data word followed by another: load spacing is the normal cycle length
    rise_q.delete();
    push(1);
    push(2);
    wait_idle(at);
    check("t2_rises", rise_q.size(), 2);
    if (rise_q.size() == 2) check("t2_gap", rise_q[1] - rise_q[0], GAP);

    // 3. six words back-to-back: ready drops at four queued
    rise_q.delete();
    for (int i = 3; i <= 7; i++) push(i);
    check("t3_ready_full", int'(bus.cmd_ready), 0);
    push(8);
    wait_idle(at);
    check("t3_rises", rise_q.size(), 6);
    for (int i = 1; i < 6; i++)
      if (i < rise_q.size()) check("t3_gap", rise_q[i] - rise_q[i-1], GAP);

    // 4. RW=1 word between two valid words
    rise_q.delete();
    d0 = drops;
    push(9);
    push(10);
    push(11);
    wait_idle(at);
    check("t4_drops", drops - d0, 1);
    check("t4_rises", rise_q.size(), 2);
    if (rise_q.size() == 2) check("t4_gap", rise_q[1] - rise_q[0], GAP + 1);
    check("t4_db_held", int'(bus.lcd_db), 8'h48);

    // 6. push coinciding with a pop at level 3
    push(12);
    la = last_push + 1;
    push(13);
    push(14);
    push(15);
    check("t6_ready_l3", int'(bus.cmd_ready), 1);
    while (cyc < la + GAP - 1) @(negedge clk);
    push(16);
    check("t6_push_edge", last_push, la + GAP);
    check("t6_ready_same", int'(bus.cmd_ready), 1);
    push(17);
    check("t6_push_next", last_push, la + GAP + 1);
    check("t6_ready_full", int'(bus.cmd_ready), 0);
    wait_idle(at);

    // 5. reset asserted while E is high
    push(18);
    push(19);
    push(20);
    begin
      int t = 0;
      while (!bus.lcd_e && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    check("t5_e_high", int'(bus.lcd_e), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_e_drop", int'(bus.lcd_e), 0);
    check("t5_busy", int'(bus.busy), 0);
    check("t5_ready", int'(bus.cmd_ready), 0);
    check("t5_on", int'(bus.lcd_on), 0);
    check("t5_db", int'(bus.lcd_db), 0);
    exp_q.delete();
    n0 = rises;
    rst = 1'b1;
    repeat (3000) @(negedge clk);
    check("t5_no_e", rises, n0);
    check("t5_busy_after", int'(bus.busy), 0);
    check("t5_on_after", int'(bus.lcd_on), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
